// File: rtl/ebtb_port_ctrl.sv
// ebtb_port_ctrl: sequences the 128x40 extended-BTB SRAM (clear sweep, 1-cycle lookups,
// buffered updates with youngest-wins bypass so lookups never see stale data).
module ebtb_port_ctrl #(
    parameter int ENTRIES       = 128,
    parameter int IDX_W         = 7,
    parameter int DATA_W        = 40,
    parameter int WB_DEPTH      = 2,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [IDX_W-1:0]  i_req_idx,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_resp_data,
    input  logic              i_upd_valid,
    output logic              o_upd_ready,
    input  logic [IDX_W-1:0]  i_upd_idx,
    input  logic [DATA_W-1:0] i_upd_data,
    input  logic              i_flush_req,
    output logic              o_busy,
    output logic              o_mem_r_en,
    output logic [IDX_W-1:0]  o_mem_r_addr,
    input  logic [DATA_W-1:0] i_mem_r_data,
    output logic              o_mem_w_en,
    output logic [IDX_W-1:0]  o_mem_w_addr,
    output logic [DATA_W-1:0] o_mem_w_data
);
    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    typedef enum logic {S_RUN, S_CLEAR} state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_wb_idx  [WB_DEPTH];
    logic [DATA_W-1:0] r_wb_data [WB_DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic              r_resp_valid;
    logic              r_hit;
    logic [DATA_W-1:0] r_byp;

    logic              w_run;
    logic              w_drain;
    logic              w_upd_ready;
    logic              w_req_acc;
    logic              w_upd_acc;
    logic              w_hit;
    logic [DATA_W-1:0] w_byp;
    logic [CNT_W-1:0]  w_tail;

    assign w_run       = r_state == S_RUN;
    // A flush kills the buffer outright, so the head must not reach the SRAM that cycle.
    assign w_drain     = w_run && r_cnt != '0 && !i_flush_req;
    assign w_upd_ready = w_run && (r_cnt < CNT_W'(WB_DEPTH) || w_drain);
    assign w_req_acc   = w_run && i_req_valid;
    assign w_upd_acc   = w_upd_ready && i_upd_valid && !i_flush_req;
    assign w_tail      = r_cnt - CNT_W'(w_drain);

    always_comb begin
        w_hit = 1'b0;
        w_byp = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CNT_W'(i) < r_cnt && r_wb_idx[i] == i_req_idx) begin
                w_hit = 1'b1;
                w_byp = r_wb_data[i];
            end
        end
        if (w_upd_acc && i_upd_idx == i_req_idx) begin
            w_hit = 1'b1;
            w_byp = i_upd_data;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= INIT_ON_RESET ? S_CLEAR : S_RUN;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_hit        <= 1'b0;
            r_byp        <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_wb_idx[i]  <= '0;
                r_wb_data[i] <= '0;
            end
        end else begin
            r_resp_valid <= w_req_acc;
            if (w_req_acc) begin
                r_hit <= w_hit;
                r_byp <= w_byp;
            end
            if (!w_run) begin
                r_ptr <= i_flush_req ? '0 : r_ptr + IDX_W'(1);
                if (r_ptr == IDX_W'(ENTRIES - 1) && !i_flush_req)
                    r_state <= S_RUN;
            end else if (i_flush_req) begin
                r_state <= S_CLEAR;
                r_ptr   <= '0;
                r_cnt   <= '0;
            end else begin
                for (int i = 0; i < WB_DEPTH - 1; i++) begin
                    if (w_drain) begin
                        r_wb_idx[i]  <= r_wb_idx[i+1];
                        r_wb_data[i] <= r_wb_data[i+1];
                    end
                end
                for (int i = 0; i < WB_DEPTH; i++) begin
                    if (w_upd_acc && CNT_W'(i) == w_tail) begin
                        r_wb_idx[i]  <= i_upd_idx;
                        r_wb_data[i] <= i_upd_data;
                    end
                end
                r_cnt <= w_tail + CNT_W'(w_upd_acc);
            end
        end
    end

    assign o_req_ready  = i_reset_n && w_run;
    assign o_upd_ready  = i_reset_n && w_upd_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_data  = !i_reset_n ? '0 : r_hit ? r_byp : i_mem_r_data;
    assign o_busy       = !w_run;
    assign o_mem_r_en   = i_reset_n && w_req_acc;
    assign o_mem_r_addr = (i_reset_n && w_req_acc) ? i_req_idx : '0;
    assign o_mem_w_en   = i_reset_n && (!w_run || w_drain);
    assign o_mem_w_addr = !i_reset_n ? '0 : w_run ? r_wb_idx[0] : r_ptr;
    assign o_mem_w_data = (!i_reset_n || !w_run) ? '0 : r_wb_data[0];
endmodule

// File: tb/tb_ebtb_port_ctrl.sv
// tb_ebtb_port_ctrl: directed + random bench; the reference keeps the architectural table
// (last accepted write per index) and a FIFO of accepted updates awaiting the SRAM.
module tb_ebtb_port_ctrl;
    localparam int WB = 2;

    typedef struct packed {
        logic [6:0]  idx;
        logic [39:0] data;
    } upd_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, upd_valid = 1'b0, flush_req = 1'b0;
    logic [6:0]  req_idx = '0, upd_idx = '0;
    logic [39:0] upd_data = '0;
    logic        req_ready, resp_valid, upd_ready, busy, mem_r_en, mem_w_en;
    logic [39:0] resp_data, mem_w_data;
    logic [39:0] mem_r_data = '0;
    logic [6:0]  mem_r_addr, mem_w_addr;

    logic [39:0] sram [128];
    logic [39:0] tbl  [128];
    upd_t        q[$];
    bit          m_clear, prev_req;
    int          m_ptr;
    logic [39:0] prev_exp;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    ebtb_port_ctrl dut (
        .i_clock(clk), .i_reset_n(reset_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_idx(req_idx),
        .o_resp_valid(resp_valid), .o_resp_data(resp_data),
        .i_upd_valid(upd_valid), .o_upd_ready(upd_ready), .i_upd_idx(upd_idx), .i_upd_data(upd_data),
        .i_flush_req(flush_req), .o_busy(busy),
        .o_mem_r_en(mem_r_en), .o_mem_r_addr(mem_r_addr), .i_mem_r_data(mem_r_data),
        .o_mem_w_en(mem_w_en), .o_mem_w_addr(mem_w_addr), .o_mem_w_data(mem_w_data)
    );

    // SRAM macro: 1R/1W, registered read
    always @(posedge clk) begin
        if (mem_w_en) sram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= sram[mem_r_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic zero_tbl();
        foreach (tbl[i]) tbl[i] = '0;
    endtask

    task automatic step(input bit rv, input logic [6:0] ri, input bit uv, input logic [6:0] ui,
                        input logic [39:0] ud, input bit fl);
        bit drain, ur, racc, uacc;
        @(negedge clk);
        req_valid = rv; req_idx = ri; upd_valid = uv; upd_idx = ui; upd_data = ud; flush_req = fl;
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(prev_req));
        if (prev_req) chk("resp_data", 64'(resp_data), 64'(prev_exp));
        chk("busy", 64'(busy), 64'(m_clear));
        chk("req_ready", 64'(req_ready), 64'(!m_clear));
        drain = !m_clear && q.size() > 0 && !fl;
        ur    = !m_clear && (q.size() < WB || drain);
        racc  = rv && !m_clear;
        uacc  = uv && ur && !fl;
        chk("upd_ready", 64'(upd_ready), 64'(ur));
        chk("mem_r_en", 64'(mem_r_en), 64'(racc));
        if (racc) chk("mem_r_addr", 64'(mem_r_addr), 64'(ri));
        chk("mem_w_en", 64'(mem_w_en), 64'(m_clear || drain));
        if (m_clear) begin
            chk("clr_addr", 64'(mem_w_addr), 64'(m_ptr));
            chk("clr_data", 64'(mem_w_data), 64'd0);
        end else if (drain) begin
            chk("wr_addr", 64'(mem_w_addr), 64'(q[0].idx));
            chk("wr_data", 64'(mem_w_data), 64'(q[0].data));
        end
        prev_req = racc;
        if (racc) prev_exp = (uacc && ui == ri) ? ud : tbl[ri];
        if (drain) void'(q.pop_front());
        if (uacc) begin
            q.push_back('{idx: ui, data: ud});
            tbl[ui] = ud;
        end
        if (fl) begin
            q.delete();
            zero_tbl();
            m_clear = 1'b1;
            m_ptr = 0;
        end else if (m_clear) begin
            if (m_ptr == 127) m_clear = 1'b0;
            m_ptr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 7'd0, 1'b0, 7'd0, 40'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; req_valid = 1'b1; upd_valid = 1'b1; req_idx = 7'd3; upd_idx = 7'd4;
        upd_data = 40'hFF; flush_req = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_upd_ready", 64'(upd_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_mem_r", 64'({mem_r_en, mem_r_addr}), 64'd0);
        chk("rst_mem_w", 64'({mem_w_en, mem_w_addr, mem_w_data}), 64'd0);
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        m_clear = 1'b1; m_ptr = 0; q.delete(); zero_tbl(); prev_req = 1'b0;
    endtask

    initial begin
        logic [39:0] d;
        zero_tbl();
        do_reset();
        idle(128);
        idle(1);
        step(1'b1, 7'd5, 1'b1, 7'd5, 40'hAB_CDEF_0123, 1'b0);
        idle(1);
        step(1'b0, 7'd0, 1'b1, 7'd9, 40'h1, 1'b0);
        step(1'b1, 7'd9, 1'b1, 7'd9, 40'h2, 1'b0);
        idle(3);
        step(1'b1, 7'd9, 1'b0, 7'd0, 40'd0, 1'b0);
        idle(1);
        chk("sram9", 64'(sram[9]), 64'h2);
        step(1'b0, 7'd0, 1'b1, 7'd20, 40'hA0, 1'b0);
        step(1'b0, 7'd0, 1'b1, 7'd21, 40'hB1, 1'b0);
        step(1'b0, 7'd0, 1'b1, 7'd22, 40'hC2, 1'b0);
        idle(3);
        step(1'b0, 7'd0, 1'b1, 7'd30, 40'h30, 1'b0);
        step(1'b0, 7'd0, 1'b1, 7'd31, 40'h31, 1'b0);
        step(1'b1, 7'd30, 1'b1, 7'd32, 40'h32, 1'b1);
        idle(128);
        step(1'b1, 7'd31, 1'b0, 7'd0, 40'd0, 1'b0);
        step(1'b1, 7'd30, 1'b0, 7'd0, 40'd0, 1'b0);
        idle(1);
        chk("sram31", 64'(sram[31]), 64'd0);
        chk("sram32", 64'(sram[32]), 64'd0);
        step(1'b0, 7'd0, 1'b0, 7'd0, 40'd0, 1'b1);
        while (m_ptr != 60) idle(1);
        do_reset();
        idle(129);
        repeat (500) begin
            d = {8'($urandom()), 32'($urandom())};
            step(1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 7'($urandom_range(0, 7)), d, $urandom_range(0, 149) == 0);
        end
        while (m_clear) idle(1);
        idle(3);
        for (int i = 0; i < 8; i++) chk("sram_final", 64'(sram[i]), 64'(tbl[i]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
